// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
module id_ex_stage #(
    parameter int unsigned ALUOP_W     = 4,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ID_Valid,
    input  logic [31:0]            ID_PC_plus4,
    input  logic [31:0]            ID_DataA,
    input  logic [31:0]            ID_DataB,
    input  logic [31:0]            ID_Imm,
    input  logic [4:0]             ID_Rs,
    input  logic [4:0]             ID_Rt,
    input  logic [4:0]             ID_Rd,
    input  logic [4:0]             ID_Shamt,
    input  logic                   ID_UsesRt,
    input  logic                   ID_RegWr,
    input  logic [1:0]             ID_RegDst,
    input  logic [1:0]             ID_MemtoReg,
    input  logic                   ID_MemWr,
    input  logic                   ID_ALUSrc,
    input  logic [ALUOP_W-1:0]     ID_ALUOp,
    input  logic                   Flush,
    input  logic                   Hold,
    output logic                   EX_Valid,
    output logic [31:0]            EX_PC_plus4,
    output logic [31:0]            EX_DataA,
    output logic [31:0]            EX_DataB,
    output logic [31:0]            EX_Imm,
    output logic [4:0]             EX_Rs,
    output logic [4:0]             EX_Rt,
    output logic [4:0]             EX_Rd,
    output logic [4:0]             EX_Shamt,
    output logic                   EX_RegWr,
    output logic [1:0]             EX_RegDst,
    output logic [1:0]             EX_MemtoReg,
    output logic                   EX_MemWr,
    output logic                   EX_ALUSrc,
    output logic [ALUOP_W-1:0]     EX_ALUOp,
    output logic                   PC_Wr,
    output logic                   IF_ID_Wr,
    output logic                   LoadUse_Stall,
    output logic [STALL_CNT_W-1:0] Stall_Count
);

    localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

    typedef struct packed {
        logic               valid;
        logic [31:0]        pc_plus4;
        logic [31:0]        data_a;
        logic [31:0]        data_b;
        logic [31:0]        imm;
        logic [4:0]         rs;
        logic [4:0]         rt;
        logic [4:0]         rd;
        logic [4:0]         shamt;
        logic               reg_wr;
        logic [1:0]         reg_dst;
        logic [1:0]         memto_reg;
        logic               mem_wr;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } stage_t;

    stage_t                 stage_q, stage_d, id_stage;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   hazard;
    logic                   load_use;

    // Gather the ID-side fields into one stage record
    always_comb begin
        id_stage           = '0;
        id_stage.valid     = ID_Valid;
        id_stage.pc_plus4  = ID_PC_plus4;
        id_stage.data_a    = ID_DataA;
        id_stage.data_b    = ID_DataB;
        id_stage.imm       = ID_Imm;
        id_stage.rs        = ID_Rs;
        id_stage.rt        = ID_Rt;
        id_stage.rd        = ID_Rd;
        id_stage.shamt     = ID_Shamt;
        id_stage.reg_wr    = ID_RegWr;
        id_stage.reg_dst   = ID_RegDst;
        id_stage.memto_reg = ID_MemtoReg;
        id_stage.mem_wr    = ID_MemWr;
        id_stage.alu_src   = ID_ALUSrc;
        id_stage.alu_op    = ID_ALUOp;
    end

    // Load in EX whose destination feeds a source of the instruction in ID;
    // suppressed by reset, Hold (already frozen) and Flush (ID is wrong-path)
    always_comb begin
        hazard   = ID_Valid & stage_q.valid & stage_q.reg_wr
                 & (stage_q.memto_reg == MEMTOREG_LOAD)
                 & (stage_q.rt != 5'd0)
                 & ((stage_q.rt == ID_Rs) | (ID_UsesRt & (stage_q.rt == ID_Rt)));
        load_use = hazard & ~Flush & ~Hold & ~reset;
    end

    // Next-state: Hold > Flush > load-use bubble > normal advance
    always_comb begin
        stage_d     = stage_q;
        stall_cnt_d = stall_cnt_q;
        if (Hold) begin
            stage_d = stage_q;
        end else if (Flush) begin
            stage_d = '0;
        end else if (load_use) begin
            stage_d = '0;
            if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
            end
        end else begin
            stage_d = id_stage;
        end
    end

    // Stage and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            stage_q     <= stage_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign PC_Wr         = reset | (~Hold & ~load_use);
    assign IF_ID_Wr      = reset | (~Hold & ~load_use);
    assign LoadUse_Stall = load_use;
    assign Stall_Count   = stall_cnt_q;

    assign EX_Valid    = stage_q.valid;
    assign EX_PC_plus4 = stage_q.pc_plus4;
    assign EX_DataA    = stage_q.data_a;
    assign EX_DataB    = stage_q.data_b;
    assign EX_Imm      = stage_q.imm;
    assign EX_Rs       = stage_q.rs;
    assign EX_Rt       = stage_q.rt;
    assign EX_Rd       = stage_q.rd;
    assign EX_Shamt    = stage_q.shamt;
    assign EX_RegWr    = stage_q.reg_wr;
    assign EX_RegDst   = stage_q.reg_dst;
    assign EX_MemtoReg = stage_q.memto_reg;
    assign EX_MemWr    = stage_q.mem_wr;
    assign EX_ALUSrc   = stage_q.alu_src;
    assign EX_ALUOp    = stage_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage (counter width 2 to reach saturation).
module tb_id_ex_stage;

    localparam int unsigned ALUOP_W     = 4;
    localparam int unsigned STALL_CNT_W = 2;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        uses_rt;
        logic        regwr;
        logic [1:0]  regdst;
        logic [1:0]  memtoreg;
        logic        memwr;
        logic        alusrc;
        logic [3:0]  aluop;
        logic [31:0] data;
    } instr_t;

    typedef struct packed {
        instr_t     id;
        logic       flush;
        logic       hold;
        logic       e_stall;
        instr_t     e_ex;
        logic [1:0] e_cnt;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   ID_Valid, ID_UsesRt, ID_RegWr, ID_MemWr, ID_ALUSrc;
    logic [31:0]            ID_PC_plus4, ID_DataA, ID_DataB, ID_Imm;
    logic [4:0]             ID_Rs, ID_Rt, ID_Rd, ID_Shamt;
    logic [1:0]             ID_RegDst, ID_MemtoReg;
    logic [ALUOP_W-1:0]     ID_ALUOp;
    logic                   Flush, Hold;
    logic                   EX_Valid, EX_RegWr, EX_MemWr, EX_ALUSrc;
    logic [31:0]            EX_PC_plus4, EX_DataA, EX_DataB, EX_Imm;
    logic [4:0]             EX_Rs, EX_Rt, EX_Rd, EX_Shamt;
    logic [1:0]             EX_RegDst, EX_MemtoReg;
    logic [ALUOP_W-1:0]     EX_ALUOp;
    logic                   PC_Wr, IF_ID_Wr, LoadUse_Stall;
    logic [STALL_CNT_W-1:0] Stall_Count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.ALUOP_W(ALUOP_W), .STALL_CNT_W(STALL_CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ID_Valid(ID_Valid), .ID_PC_plus4(ID_PC_plus4), .ID_DataA(ID_DataA),
        .ID_DataB(ID_DataB), .ID_Imm(ID_Imm), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_Rd(ID_Rd), .ID_Shamt(ID_Shamt), .ID_UsesRt(ID_UsesRt),
        .ID_RegWr(ID_RegWr), .ID_RegDst(ID_RegDst), .ID_MemtoReg(ID_MemtoReg),
        .ID_MemWr(ID_MemWr), .ID_ALUSrc(ID_ALUSrc), .ID_ALUOp(ID_ALUOp),
        .Flush(Flush), .Hold(Hold),
        .EX_Valid(EX_Valid), .EX_PC_plus4(EX_PC_plus4), .EX_DataA(EX_DataA),
        .EX_DataB(EX_DataB), .EX_Imm(EX_Imm), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt),
        .EX_Rd(EX_Rd), .EX_Shamt(EX_Shamt), .EX_RegWr(EX_RegWr),
        .EX_RegDst(EX_RegDst), .EX_MemtoReg(EX_MemtoReg), .EX_MemWr(EX_MemWr),
        .EX_ALUSrc(EX_ALUSrc), .EX_ALUOp(EX_ALUOp),
        .PC_Wr(PC_Wr), .IF_ID_Wr(IF_ID_Wr), .LoadUse_Stall(LoadUse_Stall),
        .Stall_Count(Stall_Count)
    );

    function automatic instr_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                  logic ur, logic rw, logic [1:0] rdst, logic [1:0] m2r,
                                  logic mw, logic as, logic [3:0] op, logic [31:0] d);
        instr_t i;
        i.valid = v; i.rs = rs; i.rt = rt; i.rd = rd; i.uses_rt = ur; i.regwr = rw;
        i.regdst = rdst; i.memtoreg = m2r; i.memwr = mw; i.alusrc = as; i.aluop = op;
        i.data = d;
        return i;
    endfunction

    // lw $8, off($2)
    function automatic instr_t lw8(logic [31:0] d);
        return mk(1'b1, 5'd2, 5'd8, 5'd0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1, 4'd1, d);
    endfunction

    // add $6, $8, $4
    function automatic instr_t add8(logic [31:0] d);
        return mk(1'b1, 5'd8, 5'd4, 5'd6, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 4'd2, d);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Data-side ID fields are simple functions of the instruction's data tag
    task automatic drive(input instr_t i, input logic fl, input logic hd);
        ID_Valid    = i.valid;    ID_Rs     = i.rs;      ID_Rt       = i.rt;
        ID_Rd       = i.rd;       ID_UsesRt = i.uses_rt; ID_RegWr    = i.regwr;
        ID_RegDst   = i.regdst;   ID_MemtoReg = i.memtoreg;
        ID_MemWr    = i.memwr;    ID_ALUSrc = i.alusrc;  ID_ALUOp    = i.aluop;
        ID_DataA    = i.data;
        ID_PC_plus4 = i.data + 32'd4;
        ID_DataB    = i.data << 1;
        ID_Imm      = i.data << 2;
        ID_Shamt    = 5'(i.data >> 8);
        Flush       = fl;
        Hold        = hd;
    endtask

    task automatic check_ex(input instr_t e, input logic [1:0] cnt);
        chk("EX_Valid",    32'(EX_Valid),    32'(e.valid));
        chk("EX_Rs",       32'(EX_Rs),       32'(e.rs));
        chk("EX_Rt",       32'(EX_Rt),       32'(e.rt));
        chk("EX_Rd",       32'(EX_Rd),       32'(e.rd));
        chk("EX_RegWr",    32'(EX_RegWr),    32'(e.regwr));
        chk("EX_RegDst",   32'(EX_RegDst),   32'(e.regdst));
        chk("EX_MemtoReg", 32'(EX_MemtoReg), 32'(e.memtoreg));
        chk("EX_MemWr",    32'(EX_MemWr),    32'(e.memwr));
        chk("EX_ALUSrc",   32'(EX_ALUSrc),   32'(e.alusrc));
        chk("EX_ALUOp",    32'(EX_ALUOp),    32'(e.aluop));
        chk("EX_DataA",    EX_DataA,         e.data);
        chk("EX_PC_plus4", EX_PC_plus4,      (e.data == 32'd0) ? 32'd0 : e.data + 32'd4);
        chk("EX_DataB",    EX_DataB,         e.data << 1);
        chk("EX_Imm",      EX_Imm,           e.data << 2);
        chk("EX_Shamt",    32'(EX_Shamt),    32'(5'(e.data >> 8)));
        chk("Stall_Count", 32'(Stall_Count), 32'(cnt));
    endtask

    // One cycle: drive at negedge, check stall outputs, then check EX after the edge
    task automatic step(input instr_t i, input logic fl, input logic hd,
                        input logic e_stall, input instr_t e_ex, input logic [1:0] e_cnt);
        @(negedge clk);
        drive(i, fl, hd);
        #1;
        chk("LoadUse_Stall", 32'(LoadUse_Stall), 32'(e_stall));
        chk("PC_Wr",         32'(PC_Wr),         32'(!hd && !e_stall));
        chk("IF_ID_Wr",      32'(IF_ID_Wr),      32'(!hd && !e_stall));
        @(posedge clk);
        #1;
        check_ex(e_ex, e_cnt);
    endtask

    vec_t   vecs[15];
    instr_t bub;
    instr_t add3, sw9, lw0, add0, addrt;
    logic [1:0] exp_cnt;

    initial begin
        bub   = '0;
        add3  = mk(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 4'd5, 32'h100);
        sw9   = mk(1'b1, 5'd9, 5'd8, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 4'd1, 32'h400);
        lw0   = mk(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b1, 4'd1, 32'h500);
        add0  = mk(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 4'd3, 32'h600);
        addrt = mk(1'b1, 5'd5, 5'd8, 5'd9, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 4'd4, 32'h710);

        //            id                  fl    hd    stall  expected EX          cnt
        vecs[0]  = '{add3,               1'b0, 1'b0, 1'b0, add3,                2'd0};
        vecs[1]  = '{lw8(32'h200),       1'b0, 1'b0, 1'b0, lw8(32'h200),        2'd0};
        vecs[2]  = '{add8(32'h300),      1'b0, 1'b0, 1'b1, bub,                 2'd1};
        vecs[3]  = '{add8(32'h300),      1'b0, 1'b0, 1'b0, add8(32'h300),       2'd1};
        vecs[4]  = '{lw8(32'h210),       1'b0, 1'b0, 1'b0, lw8(32'h210),        2'd1};
        vecs[5]  = '{sw9,                1'b0, 1'b0, 1'b0, sw9,                 2'd1};
        vecs[6]  = '{lw0,                1'b0, 1'b0, 1'b0, lw0,                 2'd1};
        vecs[7]  = '{add0,               1'b0, 1'b0, 1'b0, add0,                2'd1};
        vecs[8]  = '{lw8(32'h700),       1'b0, 1'b0, 1'b0, lw8(32'h700),        2'd1};
        vecs[9]  = '{addrt,              1'b1, 1'b0, 1'b0, bub,                 2'd1};
        vecs[10] = '{lw8(32'h720),       1'b0, 1'b0, 1'b0, lw8(32'h720),        2'd1};
        vecs[11] = '{add8(32'h730),      1'b0, 1'b1, 1'b0, lw8(32'h720),        2'd1};
        vecs[12] = '{add8(32'h740),      1'b1, 1'b1, 1'b0, lw8(32'h720),        2'd1};
        vecs[13] = '{add8(32'h750),      1'b0, 1'b1, 1'b0, lw8(32'h720),        2'd1};
        vecs[14] = '{add8(32'h760),      1'b1, 1'b0, 1'b0, bub,                 2'd1};

        // Reset with Hold and Flush both high: reset must win
        reset = 1'b1;
        drive(add3, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset PC_Wr",         32'(PC_Wr),         32'd1);
        chk("reset IF_ID_Wr",      32'(IF_ID_Wr),      32'd1);
        chk("reset LoadUse_Stall", 32'(LoadUse_Stall), 32'd0);
        check_ex(bub, 2'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 15; v++) begin
            step(vecs[v].id, vecs[v].flush, vecs[v].hold,
                 vecs[v].e_stall, vecs[v].e_ex, vecs[v].e_cnt);
        end

        // Repeated load-use pairs: the 2-bit counter saturates at 3
        exp_cnt = 2'd1;
        for (int k = 0; k < 5; k++) begin
            step(lw8(32'h800 + 32'(k) * 32'h10), 1'b0, 1'b0, 1'b0,
                 lw8(32'h800 + 32'(k) * 32'h10), exp_cnt);
            exp_cnt = (exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1;
            step(add8(32'h900), 1'b0, 1'b0, 1'b1, bub, exp_cnt);
        end

        // Reset arriving during a load-use hazard
        step(lw8(32'hA00), 1'b0, 1'b0, 1'b0, lw8(32'hA00), 2'd3);
        @(negedge clk);
        drive(add8(32'hA10), 1'b0, 1'b0);
        #1;
        chk("pre-reset hazard", 32'(LoadUse_Stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid reset LoadUse_Stall", 32'(LoadUse_Stall), 32'd0);
        chk("mid reset PC_Wr",         32'(PC_Wr),         32'd1);
        @(posedge clk);
        #1;
        check_ex(bub, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        step(add3, 1'b0, 1'b0, 1'b0, add3, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. Captures decoded operands and control from ID each cycle. Inserts a one-cycle bubble and stalls PC and IF/ID when a load in EX feeds the instruction in ID. Its registered Rs/Rt/control outputs drive the EX-stage forwarding unit and ALU directly.

Parameters:
ALUOP_W, 4, width of ALU operation code
STALL_CNT_W, 16, width of saturating load-use stall counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
ID_Valid  in  1  ID holds a real instruction
ID_PC_plus4  in  32  PC+4 of ID instruction
ID_DataA  in  32  register file read port A
ID_DataB  in  32  register file read port B
ID_Imm  in  32  extended immediate
ID_Rs  in  5  source register rs
ID_Rt  in  5  source/dest register rt
ID_Rd  in  5  dest register rd
ID_Shamt  in  5  shift amount
ID_UsesRt  in  1  instruction reads rt as an ALU operand
ID_RegWr  in  1  register write enable
ID_RegDst  in  2  00 rd, 01 rt, 10 r31
ID_MemtoReg  in  2  01 = load result
ID_MemWr  in  1  store
ID_ALUSrc  in  1  B operand is immediate
ID_ALUOp  in  ALUOP_W  ALU operation
Flush  in  1  branch/jump taken in EX, ID instruction is wrong-path
Hold  in  1  global pipeline freeze (memory wait)
EX_* (Valid, PC_plus4, DataA, DataB, Imm, Rs, Rt, Rd, Shamt, RegWr, RegDst, MemtoReg, MemWr, ALUSrc, ALUOp)  out  same widths as ID_*  registered stage contents
PC_Wr  out  1  PC write enable
IF_ID_Wr  out  1  IF/ID register write enable
LoadUse_Stall  out  1  hazard detected this cycle
Stall_Count  out  STALL_CNT_W  number of bubbles inserted

Behaviour:
- Reset (sync, active-high): every EX_* output = 0, Stall_Count = 0. Outputs PC_Wr = IF_ID_Wr = 1 and LoadUse_Stall = 0 while reset is high. Reset overrides Hold and Flush.
- Hazard (combinational from current EX_* and ID_*): LoadUse_Stall = ID_Valid & EX_Valid & EX_RegWr & (EX_MemtoReg==01) & (EX_Rt!=0) & ((EX_Rt==ID_Rs) | (ID_UsesRt & EX_Rt==ID_Rt)). It is forced to 0 when Flush=1.
- A store whose only match is rt (ID_MemWr=1, ID_UsesRt=0) does not stall; MEM-stage lw-sw forwarding covers it.
- PC_Wr = IF_ID_Wr = ~Hold & ~LoadUse_Stall.
- Register update priority per edge: reset > Hold > Flush > LoadUse_Stall > normal.
  - Hold: all EX_* keep their value; counter unchanged.
  - Flush: load bubble.
  - LoadUse_Stall: load bubble; Stall_Count += 1, saturating at all-ones.
  - Normal: EX_* <= ID_*.
- Bubble: EX_Valid, RegWr, MemWr, MemtoReg, RegDst, ALUSrc, ALUOp all 0. Data/register fields also 0 so a bubble never matches a forwarding compare (Rs/Rt = 0).
- Latency: 1 cycle ID->EX. A load-use stall lasts exactly 1 cycle: the bubble in EX clears the hazard next cycle, and the consumer then reaches EX while the load is in MEM/WB, so it is served by MEM/WB forwarding.
- The Flush source keeps Flush asserted for as long as Hold is high; Flush is only acted on once Hold is low.
- Hazard during Hold: stall outputs stay low (Hold already freezes everything). Detection re-evaluates when Hold drops.
- Back-to-back loads: each dependent pair costs one bubble; there is no cumulative state beyond the counter.

Test Plan:
- Reset then ID_Valid=1, ID_Rs=3, ID_RegWr=1, ID_ALUOp=5 -> next cycle EX_Rs=3, EX_RegWr=1, EX_ALUOp=5, PC_Wr=1; all EX_* were 0 during reset.
- EX holds lw $8 (MemtoReg=01, RegWr=1, Rt=8); ID holds add with Rs=8 -> LoadUse_Stall=1, PC_Wr=0, IF_ID_Wr=0. Next cycle EX_Valid=0, EX_RegWr=0, Stall_Count=1, LoadUse_Stall=0, add enters EX the cycle after.
- EX holds lw $8; ID holds sw with Rt=8, ID_UsesRt=0, Rs=9 -> no stall, EX_* <= sw fields next cycle. Same case with EX_Rt=0 (lw $0) and ID_Rs=0 -> no stall.
- Load-use hazard with Flush=1 in the same cycle -> LoadUse_Stall=0, PC_Wr=1, bubble loaded, Stall_Count unchanged.
- Hold=1 for 3 cycles with a varying ID_* -> EX_* constant, PC_Wr=0. Hold drops with Flush=1 -> bubble loaded on that edge.
- STALL_CNT_W=2: force 5 consecutive load-use stalls -> Stall_Count reaches 3 and stays 3. Assert reset mid-stall -> next cycle all EX_*=0, Stall_Count=0.
